// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file: registered reads with write-first bypass, read stall hold,
// and a post-reset init sequencer that clears the array. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_param #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 5,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;

  // State register and init pointer; rst restarts the full clear sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_ptr <= init_ptr + ADDR_W'(1);
    end
  end

  // The edge that clears the last entry also moves to RUN.
  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_ptr == LAST_PTR) state_next = ST_RUN;
  end

  // write_en and read_en are single-cycle strobes sampled on the rising edge; there is no
  // back-pressure, and both are ignored while busy is high.
  always_comb begin
    busy  = (state == ST_INIT);
    run   = (state == ST_RUN);
`ifdef REGFILE_ZERO_REG_EN
    wr_ok = run && write_en && (write_reg != '0);
`else
    wr_ok = run && write_en;
`endif
    mem_we    = wr_ok || (busy && !rst);
    mem_waddr = busy ? init_ptr  : write_reg;
    mem_wdata = busy ? RESET_VAL : write_data;
  end

  // Write-first bypass per port; under the zero-register option entry 0 always reads as 0.
  always_comb begin
    rd1_val = (wr_ok && write_reg == read_reg1) ? write_data : mem[read_reg1];
    rd2_val = (wr_ok && write_reg == read_reg2) ? write_data : mem[read_reg2];
`ifdef REGFILE_ZERO_REG_EN
    if (read_reg1 == '0) rd1_val = '0;
    if (read_reg2 == '0) rd2_val = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out1 <= '0;
      data_out2 <= '0;
    end else if (run && read_en) begin
      data_out1 <= rd1_val;
      data_out2 <= rd2_val;
    end
  end

endmodule
